lsu_dccm_dma_arb: RTL and testbench

Arbitrates the single DCCM port between the LSU decode-stage request and the DMA slave request. LSU has default priority; a saturating starvation counter guarantees DMA forward progress by stalling LSU decode. Tracks in-flight DMA reads through a fixed-latency pipe. Produces the `dma_dccm_req` / `dma_mem_write` clock-enable terms consumed by the LSU clock domain, and honours `lsu_freeze_dc3`.

---
 rtl/lsu_dccm_dma_arb.sv | 97 +++++++++
 tb/tb_lsu_dccm_dma_arb.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dccm_dma_arb.sv
// lsu_dccm_dma_arb
// Shares the single DCCM port between the LSU decode-stage request and the DMA
// slave. The LSU wins by default. A saturating starvation counter forces a DMA
// beat through by stalling LSU decode. Granted DMA reads are tracked through a
// fixed-latency pipe so that the read-done pulse and the outstanding count stay
// exact.
module lsu_dccm_dma_arb #(
    parameter int DMA_STARVE_MAX = 8,
    parameter int DMA_RD_LAT     = 3,
    parameter int DMA_MAX_OUTST  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lsu_req,
    input  logic       lsu_freeze_dc3,
    input  logic       dma_req,
    input  logic       dma_write,
    output logic       dma_gnt,
    output logic       dma_ready,
    output logic       lsu_stall_dec,
    output logic       dma_rd_done,
    output logic       dma_dccm_req,
    output logic       dma_mem_write,
    output logic [3:0] dma_starve_cnt
);

    localparam logic [3:0] STARVE_MAX = 4'(DMA_STARVE_MAX);
    localparam logic [2:0] MAX_OUTST  = 3'(DMA_MAX_OUTST);

    logic [3:0]            starve_cnt;
    logic [2:0]            outst_cnt;
    logic [DMA_RD_LAT-1:0] rd_pipe;
    logic [DMA_RD_LAT-1:0] rd_pipe_next;
    logic                  force_dma;
    logic                  rd_gnt;

    // Once the DMA has waited its full allowance, it takes the port even from the LSU.
    assign force_dma = (starve_cnt == STARVE_MAX);

    // Only reads consume an outstanding slot, so only reads wait on dma_ready.
    assign dma_ready = (outst_cnt < MAX_OUTST);

    assign dma_gnt = ~rst & dma_req & ~lsu_freeze_dc3 & (dma_write | dma_ready)
                   & (~lsu_req | force_dma);

    assign rd_gnt         = dma_gnt & ~dma_write;
    assign lsu_stall_dec  = dma_gnt & lsu_req;
    assign dma_rd_done    = rd_pipe[DMA_RD_LAT-1];
    assign dma_dccm_req   = dma_gnt | (outst_cnt != 3'd0);
    assign dma_mem_write  = dma_gnt & dma_write;
    assign dma_starve_cnt = starve_cnt;

    // Shift the read pipe by one and insert this cycle's read grant at the bottom.
    // The shift form stays legal even when the pipe is a single bit wide.
    always_comb begin
        rd_pipe_next    = rd_pipe << 1;
        rd_pipe_next[0] = rd_gnt;
    end

    // Read pipe. A freeze does not stall it, so granted reads always complete.
    // A reset discards every read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= rd_pipe_next;
        end
    end

    // Starvation counter. It clears on a grant or when no request is present,
    // holds during a freeze, and otherwise counts denied cycles up to the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (dma_gnt || !dma_req) begin
            starve_cnt <= '0;
        end else if (lsu_freeze_dc3) begin
            starve_cnt <= starve_cnt;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Outstanding read count. A read grant and a completion in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            outst_cnt <= '0;
        end else begin
            case ({rd_gnt, dma_rd_done})
                2'b10:   outst_cnt <= outst_cnt + 3'd1;
                2'b01:   outst_cnt <= outst_cnt - 3'd1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_dccm_dma_arb.sv
// Testbench for lsu_dccm_dma_arb: directed scenarios with literal expectations,
// followed by a randomized phase. Every cycle is compared against a behavioural
// model that tracks read completion times in a queue.
module tb_lsu_dccm_dma_arb;

    localparam int STARVE_MAX = 8;
    localparam int RD_LAT     = 3;
    localparam int MAX_OUTST  = 2;

    logic       clk;
    logic       rst;
    logic       lsu_req;
    logic       lsu_freeze_dc3;
    logic       dma_req;
    logic       dma_write;
    logic       dma_gnt;
    logic       dma_ready;
    logic       lsu_stall_dec;
    logic       dma_rd_done;
    logic       dma_dccm_req;
    logic       dma_mem_write;
    logic [3:0] dma_starve_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: the starvation count, plus the completion cycle of each read in flight.
    int starve_m = 0;
    int pend[$];
    int cyc = 0;
    bit chk_en = 0;
    bit exp_gnt, exp_ready, exp_done, exp_stall, exp_dccm, exp_memw;

    lsu_dccm_dma_arb #(
        .DMA_STARVE_MAX(STARVE_MAX),
        .DMA_RD_LAT    (RD_LAT),
        .DMA_MAX_OUTST (MAX_OUTST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_req        (lsu_req),
        .lsu_freeze_dc3 (lsu_freeze_dc3),
        .dma_req        (dma_req),
        .dma_write      (dma_write),
        .dma_gnt        (dma_gnt),
        .dma_ready      (dma_ready),
        .lsu_stall_dec  (lsu_stall_dec),
        .dma_rd_done    (dma_rd_done),
        .dma_dccm_req   (dma_dccm_req),
        .dma_mem_write  (dma_mem_write),
        .dma_starve_cnt (dma_starve_cnt)
    );

    // Free-running clock with a period of 10 time units.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic r, input logic l, input logic f,
                                 input logic q, input logic w);
        rst            = r;
        lsu_req        = l;
        lsu_freeze_dc3 = f;
        dma_req        = q;
        dma_write      = w;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One cycle: drive the inputs just after the clock edge, compare the DUT
    // outputs against the model, then advance the model across the next edge.
    task automatic stepCycle(input logic r, input logic l, input logic f,
                             input logic q, input logic w);
        @(posedge clk);
        #1;
        applyStimulus(r, l, f, q, w);
        #1;
        exp_ready = (pend.size() < MAX_OUTST);
        exp_gnt   = !r && q && !f && (w || exp_ready) && (!l || starve_m == STARVE_MAX);
        exp_done  = (pend.size() != 0) && (pend[0] == cyc);
        exp_stall = exp_gnt && l;
        exp_dccm  = exp_gnt || (pend.size() != 0);
        exp_memw  = exp_gnt && w;
        if (chk_en) begin
            checkOutput("dma_gnt",        {3'b0, dma_gnt},       {3'b0, exp_gnt});
            checkOutput("dma_ready",      {3'b0, dma_ready},     {3'b0, exp_ready});
            checkOutput("lsu_stall_dec",  {3'b0, lsu_stall_dec}, {3'b0, exp_stall});
            checkOutput("dma_rd_done",    {3'b0, dma_rd_done},   {3'b0, exp_done});
            checkOutput("dma_dccm_req",   {3'b0, dma_dccm_req},  {3'b0, exp_dccm});
            checkOutput("dma_mem_write",  {3'b0, dma_mem_write}, {3'b0, exp_memw});
            checkOutput("dma_starve_cnt", dma_starve_cnt,        4'(starve_m));
        end
        while (pend.size() != 0 && pend[0] <= cyc) void'(pend.pop_front());
        if (r) begin
            pend.delete();
            starve_m = 0;
        end else begin
            if (exp_gnt && !w) pend.push_back(cyc + RD_LAT);
            if (exp_gnt || !q) starve_m = 0;
            else if (!f && starve_m < STARVE_MAX) starve_m++;
        end
        cyc++;
    endtask

    initial begin
        bit pending;
        bit pend_wr;
        bit r;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset, then idle write grant in cycle 5.
        stepCycle(1, 0, 0, 0, 0);
        chk_en = 1;
        stepCycle(1, 0, 0, 0, 0);
        for (int i = 0; i <= 5; i++) begin
            stepCycle(0, 0, 0, i == 5, i == 5);
            if (i == 0) begin
                checkOutput("lit_reset_ready", {3'b0, dma_ready}, 4'd1);
                checkOutput("lit_reset_dccm",  {3'b0, dma_dccm_req}, 4'd0);
            end
            if (i == 5) begin
                checkOutput("lit_idle_gnt",   {3'b0, dma_gnt}, 4'd1);
                checkOutput("lit_idle_memw",  {3'b0, dma_mem_write}, 4'd1);
                checkOutput("lit_idle_stall", {3'b0, lsu_stall_dec}, 4'd0);
            end
        end
        stepCycle(0, 0, 0, 0, 0);
        checkOutput("lit_idle_cnt", dma_starve_cnt, 4'd0);

        // Starvation under continuous LSU traffic.
        for (int k = 0; k <= 11; k++) begin
            stepCycle(0, 1, 0, k <= 8, 0);
            if (k <= 8) checkOutput("lit_starve_cnt", dma_starve_cnt, 4'(k));
            if (k == 7) checkOutput("lit_starve_nogn", {3'b0, dma_gnt}, 4'd0);
            if (k == 8) begin
                checkOutput("lit_starve_gnt",   {3'b0, dma_gnt}, 4'd1);
                checkOutput("lit_starve_stall", {3'b0, lsu_stall_dec}, 4'd1);
            end
            if (k == 9)  checkOutput("lit_starve_clr", dma_starve_cnt, 4'd0);
            if (k == 10) checkOutput("lit_starve_nodone", {3'b0, dma_rd_done}, 4'd0);
            if (k == 11) checkOutput("lit_starve_done", {3'b0, dma_rd_done}, 4'd1);
        end

        // Read backpressure with back-to-back reads.
        for (int k = 0; k <= 8; k++) begin
            stepCycle(0, 0, 0, k <= 4, 0);
            if (k == 0 || k == 1 || k == 4) checkOutput("lit_bp_gnt", {3'b0, dma_gnt}, 4'd1);
            if (k == 2) begin
                checkOutput("lit_bp_ready0", {3'b0, dma_ready}, 4'd0);
                checkOutput("lit_bp_nogn2",  {3'b0, dma_gnt}, 4'd0);
            end
            if (k == 3) checkOutput("lit_bp_nogn3", {3'b0, dma_gnt}, 4'd0);
            if (k == 3 || k == 4 || k == 7) checkOutput("lit_bp_done", {3'b0, dma_rd_done}, 4'd1);
            if (k == 5 || k == 6) checkOutput("lit_bp_nodone", {3'b0, dma_rd_done}, 4'd0);
            if (k == 5) begin
                checkOutput("lit_bp_ready5", {3'b0, dma_ready}, 4'd1);
                checkOutput("lit_bp_dccm5",  {3'b0, dma_dccm_req}, 4'd1);
            end
            if (k == 8) checkOutput("lit_bp_dccm8", {3'b0, dma_dccm_req}, 4'd0);
        end

        // A write while dma_ready is low is granted immediately.
        for (int k = 0; k <= 6; k++) begin
            stepCycle(0, 0, 0, k <= 2, k == 2);
            if (k == 2) begin
                checkOutput("lit_wr_ready", {3'b0, dma_ready}, 4'd0);
                checkOutput("lit_wr_gnt",   {3'b0, dma_gnt}, 4'd1);
                checkOutput("lit_wr_memw",  {3'b0, dma_mem_write}, 4'd1);
            end
        end

        // Freeze with a read in flight, then freeze while the counter is at 5.
        for (int n = 0; n <= 19; n++) begin
            stepCycle(0, n >= 1, (n >= 1 && n <= 3) || (n >= 9 && n <= 12), n <= 16, 0);
            if (n == 0) checkOutput("lit_fz_gnt0", {3'b0, dma_gnt}, 4'd1);
            if (n == 2) checkOutput("lit_fz_nodone", {3'b0, dma_rd_done}, 4'd0);
            if (n == 3) checkOutput("lit_fz_done", {3'b0, dma_rd_done}, 4'd1);
            if (n >= 9 && n <= 12) begin
                checkOutput("lit_fz_hold",   dma_starve_cnt, 4'd5);
                checkOutput("lit_fz_nogn",   {3'b0, dma_gnt}, 4'd0);
            end
            if (n == 13) checkOutput("lit_fz_cnt13", dma_starve_cnt, 4'd5);
            if (n == 14) checkOutput("lit_fz_cnt14", dma_starve_cnt, 4'd6);
            if (n == 16) checkOutput("lit_fz_force", {3'b0, lsu_stall_dec}, 4'd1);
            if (n == 19) checkOutput("lit_fz_done19", {3'b0, dma_rd_done}, 4'd1);
        end

        // Reset one cycle after a read grant discards the read.
        stepCycle(0, 0, 0, 1, 0);
        checkOutput("lit_rst_gnt0", {3'b0, dma_gnt}, 4'd1);
        stepCycle(1, 0, 0, 1, 1);
        checkOutput("lit_rst_forced", {3'b0, dma_gnt}, 4'd0);
        stepCycle(1, 0, 0, 0, 0);
        checkOutput("lit_rst_dccm",  {3'b0, dma_dccm_req}, 4'd0);
        checkOutput("lit_rst_ready", {3'b0, dma_ready}, 4'd1);
        checkOutput("lit_rst_done",  {3'b0, dma_rd_done}, 4'd0);
        stepCycle(0, 0, 0, 1, 1);
        checkOutput("lit_rst_first", {3'b0, dma_gnt}, 4'd1);
        checkOutput("lit_rst_nodone", {3'b0, dma_rd_done}, 4'd0);
        for (int k = 0; k < 4; k++) begin
            stepCycle(0, 0, 0, 0, 0);
            checkOutput("lit_rst_quiet", {3'b0, dma_rd_done}, 4'd0);
        end

        // Randomized traffic. A DMA request is held until it is granted.
        pending = 0;
        pend_wr = 0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            if (r) pending = 0;
            else if (!pending && $urandom_range(0, 2) == 0) begin
                pending = 1;
                pend_wr = 1'($urandom_range(0, 1));
            end
            stepCycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, pending, pend_wr);
            if (exp_gnt) pending = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
